decode_buffer: RTL

Decoupling FIFO between the decode stage and the scheduler. It holds fully decoded instruction bundles: PC, exception info, immediates, register indices, functional-unit valid and micro-op. The decoder keeps producing while the scheduler stalls on hazards, fences or pending CSR writes. The whole contents are discarded on a pipeline flush.

---
 rtl/decode_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_buffer
// Description : Circular FIFO of fully decoded instruction bundles that sits
//               between the decode stage and the scheduler. It absorbs
//               scheduler/back-end stalls and is emptied by a pipeline flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_buffer #(
    parameter int DEPTH           = 4,  // entries, power of two, >= 2
    parameter int EXU_VALID_WIDTH = 4,  // width of the functional-unit one-hot
    parameter int EXU_UOP_WIDTH   = 7   // width of the functional-unit micro-op
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       write_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       valid_o,

    input  logic [31:0]                instr_address_i,
    input  logic                       compressed_i,
    input  logic                       exception_generated_i,
    input  logic [4:0]                 exception_vector_i,
    input  logic                       save_next_pc_i,
    input  logic                       fence_i,
    input  logic [63:0]                immediate_i,        // {imm[1], imm[0]}
    input  logic [1:0]                 immediate_valid_i,
    input  logic [9:0]                 src_reg_i,          // {src[1], src[0]}
    input  logic [4:0]                 dest_reg_i,
    input  logic [EXU_VALID_WIDTH-1:0] exu_valid_i,
    input  logic [EXU_UOP_WIDTH-1:0]   exu_uop_i,

    output logic [31:0]                instr_address_o,
    output logic                       compressed_o,
    output logic                       exception_generated_o,
    output logic [4:0]                 exception_vector_o,
    output logic                       save_next_pc_o,
    output logic                       fence_o,
    output logic [63:0]                immediate_o,
    output logic [1:0]                 immediate_valid_o,
    output logic [9:0]                 src_reg_o,
    output logic [4:0]                 dest_reg_o,
    output logic [EXU_VALID_WIDTH-1:0] exu_valid_o,
    output logic [EXU_UOP_WIDTH-1:0]   exu_uop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // Pointers, occupancy and handshake decodes
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Flags decode registered occupancy only, so write_i/stall_i never reach
    // full_o/empty_o combinationally.
    assign full_o  = (count == C_DEPTH);
    assign empty_o = (count == '0);
    assign valid_o = !empty_o;

    // A pop while full does not free the slot for this cycle's write: push
    // looks only at full_o, never at pop.
    assign push = write_i & !full_o & !flush_i;
    assign pop  = valid_o & !stall_i & !flush_i;

    // ------------------------------------------------------------------------
    // Bundle storage (not reset; contents are meaningless while count == 0)
    // ------------------------------------------------------------------------
    logic [31:0]                addr_mem      [DEPTH];
    logic                       compressed_mem[DEPTH];
    logic                       exc_gen_mem   [DEPTH];
    logic [4:0]                 exc_vec_mem   [DEPTH];
    logic                       save_pc_mem   [DEPTH];
    logic                       fence_mem     [DEPTH];
    logic [63:0]                imm_mem       [DEPTH];
    logic [1:0]                 imm_valid_mem [DEPTH];
    logic [9:0]                 src_reg_mem   [DEPTH];
    logic [4:0]                 dest_reg_mem  [DEPTH];
    logic [EXU_VALID_WIDTH-1:0] exu_valid_mem [DEPTH];
    logic [EXU_UOP_WIDTH-1:0]   exu_uop_mem   [DEPTH];

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else if (flush_i) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                write_ptr <= write_ptr + PTR_W'(1);
            end
            if (pop) begin
                read_ptr <= read_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture the presented bundle into the slot at write_ptr on a push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[write_ptr]       <= instr_address_i;
            compressed_mem[write_ptr] <= compressed_i;
            exc_gen_mem[write_ptr]    <= exception_generated_i;
            exc_vec_mem[write_ptr]    <= exception_vector_i;
            save_pc_mem[write_ptr]    <= save_next_pc_i;
            fence_mem[write_ptr]      <= fence_i;
            imm_mem[write_ptr]        <= immediate_i;
            imm_valid_mem[write_ptr]  <= immediate_valid_i;
            src_reg_mem[write_ptr]    <= src_reg_i;
            dest_reg_mem[write_ptr]   <= dest_reg_i;
            exu_valid_mem[write_ptr]  <= exu_valid_i;
            exu_uop_mem[write_ptr]    <= exu_uop_i;
        end
    end

    // ------------------------------------------------------------------------
    // Head presentation. Fields that cause downstream action are masked on a
    // bubble so stale storage never issues an op or raises an exception.
    // ------------------------------------------------------------------------
    assign instr_address_o       = addr_mem[read_ptr];
    assign compressed_o          = compressed_mem[read_ptr];
    assign exception_generated_o = empty_o ? 1'b0 : exc_gen_mem[read_ptr];
    assign exception_vector_o    = exc_vec_mem[read_ptr];
    assign save_next_pc_o        = save_pc_mem[read_ptr];
    assign fence_o               = fence_mem[read_ptr];
    assign immediate_o           = imm_mem[read_ptr];
    assign immediate_valid_o     = imm_valid_mem[read_ptr];
    assign src_reg_o             = src_reg_mem[read_ptr];
    assign dest_reg_o            = dest_reg_mem[read_ptr];
    assign exu_valid_o           = empty_o ? '0 : exu_valid_mem[read_ptr];
    assign exu_uop_o             = exu_uop_mem[read_ptr];

endmodule
`default_nettype wire
